// File: rtl/sfx_player.sv
// Sound-effect player: plays one of four fixed note sequences as a square-wave
// tone, gated by a volume-controlled PWM carrier, on the amplifier PWM pin.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   trigger            - start request; effect_sel is latched with it
//   effect_sel[1:0]    - effect index
//   volume[DUTY_W-1:0] - carrier duty, used live
//   busy, done         - playing flag, one-cycle completion pulse
//   AUD_PWM, AUD_SD    - amplifier PWM and amplifier enable (= busy)
module sfx_player #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned DUTY_W       = 4,
    parameter int unsigned ALLOW_RETRIG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [1:0]        effect_sel,
    input  logic [DUTY_W-1:0] volume,
    output logic              busy,
    output logic              done,
    output logic              AUD_PWM,
    output logic              AUD_SD
);

    localparam int unsigned TICK_CYC = CLK_HZ / 1000;
    localparam int unsigned TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    // 262 Hz is the lowest note, so it sets the longest half-period.
    localparam int unsigned HALF_MAX = CLK_HZ / (2 * 262);
    localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int unsigned MS_W     = $clog2(400);

    localparam int unsigned H1320 = CLK_HZ / (2 * 1320);
    localparam int unsigned H880  = CLK_HZ / (2 * 880);
    localparam int unsigned H523  = CLK_HZ / (2 * 523);
    localparam int unsigned H440  = CLK_HZ / (2 * 440);
    localparam int unsigned H392  = CLK_HZ / (2 * 392);
    localparam int unsigned H330  = CLK_HZ / (2 * 330);
    localparam int unsigned H262  = CLK_HZ / (2 * 262);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          effect_q, effect_d;
    logic [1:0]          note_q, note_d;
    logic [MS_W-1:0]     ms_q, ms_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic                phase_q, phase_d;
    logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pwm_q, pwm_d;
    logic                start;
    logic [HALF_W-1:0]   cur_half;
    logic [MS_W-1:0]     cur_dur;
    logic [1:0]          last_note;

    // Half-period in clk cycles of note idx of effect eff.
    function automatic logic [HALF_W-1:0] note_half(input logic [1:0] eff, input logic [1:0] idx);
        logic [HALF_W-1:0] h;
        h = HALF_W'(H880);
        case (eff)
            2'd0:    h = (idx == 2'd0) ? HALF_W'(H880) : HALF_W'(H1320);
            2'd1: begin
                case (idx)
                    2'd0:    h = HALF_W'(H440);
                    2'd1:    h = HALF_W'(H330);
                    default: h = HALF_W'(H262);
                endcase
            end
            2'd2:    h = idx[0] ? HALF_W'(H440) : HALF_W'(H880);
            default: begin
                case (idx)
                    2'd0:    h = HALF_W'(H262);
                    2'd1:    h = HALF_W'(H330);
                    2'd2:    h = HALF_W'(H392);
                    default: h = HALF_W'(H523);
                endcase
            end
        endcase
        return h;
    endfunction

    // Duration in ms of note idx of effect eff.
    function automatic logic [MS_W-1:0] note_dur(input logic [1:0] eff, input logic [1:0] idx);
        logic [MS_W-1:0] d;
        case (eff)
            2'd0:    d = MS_W'(50);
            2'd1:    d = (idx == 2'd2) ? MS_W'(400) : MS_W'(200);
            2'd2:    d = MS_W'(100);
            default: d = MS_W'(80);
        endcase
        return d;
    endfunction

    assign cur_half  = note_half(effect_q, note_q);
    assign cur_dur   = note_dur(effect_q, note_q);
    assign last_note = (effect_q == 2'd0) ? 2'd1 : ((effect_q == 2'd1) ? 2'd2 : 2'd3);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        effect_d  = effect_q;
        note_d    = note_q;
        ms_d      = ms_q;
        tick_d    = tick_q;
        half_d    = half_q;
        phase_d   = phase_q;
        pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
        start     = 1'b0;

        case (state_q)
            S_IDLE: begin
                start = trigger;
            end
            S_PLAY: begin
                if (trigger && (ALLOW_RETRIG != 0)) begin
                    start = 1'b1;
                end else begin
                    // Tone square wave.
                    if (half_q == cur_half - HALF_W'(1)) begin
                        half_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                    end
                    // ms tick and note sequencing; a note boundary overrides the tone update.
                    if (tick_q == TICK_W'(TICK_CYC - 1)) begin
                        tick_d = '0;
                        if (ms_q == cur_dur - MS_W'(1)) begin
                            ms_d    = '0;
                            half_d  = '0;
                            phase_d = 1'b0;
                            if (note_q == last_note) begin
                                state_d = S_DONE;
                            end else begin
                                note_d = note_q + 2'd1;
                            end
                        end else begin
                            ms_d = ms_q + MS_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start) begin
            state_d  = S_PLAY;
            effect_d = effect_sel;
            note_d   = '0;
            ms_d     = '0;
            tick_d   = '0;
            half_d   = '0;
            phase_d  = 1'b0;
        end

        busy_d = (state_d == S_PLAY);
        done_d = (state_q == S_PLAY) && (state_d == S_DONE);
        pwm_d  = busy_d && phase_d && (pwm_cnt_d < volume);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            effect_q  <= '0;
            note_q    <= '0;
            ms_q      <= '0;
            tick_q    <= '0;
            half_q    <= '0;
            phase_q   <= 1'b0;
            pwm_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            effect_q  <= effect_d;
            note_q    <= note_d;
            ms_q      <= ms_d;
            tick_q    <= tick_d;
            half_q    <= half_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pwm_q     <= pwm_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign AUD_PWM = pwm_q;
    assign AUD_SD  = busy_q;

endmodule

// File: tb/tb_sfx_player.sv
// Bench for sfx_player at a scaled clock (20 kHz, 20-cycle ms tick) with one
// retriggerable and one non-retriggerable instance sharing the stimulus.
module tb_sfx_player;

    localparam int unsigned CLK_HZ = 20_000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trigger;
    logic [1:0] effect_sel;
    logic [3:0] volume;
    logic       busy0, done0, pwm0, sd0;
    logic       busy1, done1, pwm1, sd1;

    always #5 clk = ~clk;

    sfx_player #(.CLK_HZ(CLK_HZ), .DUTY_W(4), .ALLOW_RETRIG(1)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .effect_sel(effect_sel),
        .volume(volume), .busy(busy0), .done(done0), .AUD_PWM(pwm0), .AUD_SD(sd0)
    );

    sfx_player #(.CLK_HZ(CLK_HZ), .DUTY_W(4), .ALLOW_RETRIG(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .effect_sel(effect_sel),
        .volume(volume), .busy(busy1), .done(done1), .AUD_PWM(pwm1), .AUD_SD(sd1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected end of each busy run: length (-1 = not checked) and done level.
    typedef struct {
        int len;
        int done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic push_exp(input int len0, input int len1, input int dn);
        exp_t e;
        e.len = len0; e.done = dn; q0.push_back(e);
        e.len = len1; q1.push_back(e);
    endtask

    // Model of the free-running carrier counter.
    logic [3:0] pcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcnt <= 4'd0;
        else        pcnt <= pcnt + 4'd1;
    end

    // Scoreboard monitor: pops an expectation whenever a busy run ends.
    int   run_len[2]   = '{0, 0};
    logic busy_prev[2] = '{1'b0, 1'b0};
    int   done_cnt[2]  = '{0, 0};
    int   sd_err = 0;
    int   both_err = 0;

    always @(negedge clk) begin
        logic b, d, s;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            b = (i == 0) ? busy0 : busy1;
            d = (i == 0) ? done0 : done1;
            s = (i == 0) ? sd0 : sd1;
            if (s !== b) sd_err++;
            if (b && d) both_err++;
            if (d) done_cnt[i]++;
            if (b) run_len[i]++;
            if (busy_prev[i] && !b) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    check($sformatf("sb_underflow%0d", i), 1, 0);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (e.len >= 0) check($sformatf("busy_len%0d", i), run_len[i], e.len);
                    check($sformatf("done_at_end%0d", i), int'(d), e.done);
                end
                run_len[i] = 0;
            end
            busy_prev[i] = b;
        end
    end

    int off;

    task automatic step();
        @(negedge clk);
        off++;
    endtask

    task automatic run_to(input int target);
        while (off < target) step();
    endtask

    task automatic pulse(input logic [1:0] sel);
        @(negedge clk);
        trigger    = 1'b1;
        effect_sel = sel;
        @(negedge clk);
        trigger = 1'b0;
        off     = 0;
        check($sformatf("busy_rise_e%0d", sel), int'(busy0), 1);
    endtask

    // Compare AUD_PWM with the ideal tone (phase low first) gated by the carrier.
    task automatic tone_window(input string tag, input int nstart, input int half, input int len);
        int   mism;
        logic ex;
        mism = 0;
        for (int k = 0; k < len; k++) begin
            ex = (((off - nstart) / half) % 2 == 1) && (pcnt < volume);
            if (pwm0 !== ex) mism++;
            step();
        end
        check(tag, mism, 0);
    endtask

    task automatic wait_done(input int which, input string tag, output int hi);
        logic d;
        hi = 0;
        d  = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            d = (which == 0) ? done0 : done1;
            if (d) break;
            if (((which == 0) ? pwm0 : pwm1) === 1'b1) hi++;
            step();
        end
        check(tag, int'(d), 1);
    endtask

    initial begin
        int hi;
        rst_n      = 1'b0;
        trigger    = 1'b0;
        effect_sel = 2'd0;
        volume     = 4'd0;
        off        = 0;
        #1;
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_pwm",  int'(pwm0),  0);
        check("rst_sd",   int'(sd0),   0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy0), 0);

        // Effect 0, full volume: 100 ms, halves of 11 then 7 cycles.
        volume = 4'd15;
        push_exp(2000, 2000, 1);
        pulse(2'd0);
        tone_window("e0_note0", 0, 11, 200);
        run_to(1000);
        tone_window("e0_note1", 1000, 7, 60);
        wait_done(0, "e0_done", hi);

        // Effect 1, zero volume: silent but full 800 ms timing.
        volume = 4'd0;
        push_exp(16000, 16000, 1);
        pulse(2'd1);
        wait_done(0, "e1_done", hi);
        check("e1_pwm_high", hi, 0);
        // Trigger presented during the DONE cycle is ignored.
        trigger    = 1'b1;
        effect_sel = 2'd2;
        @(negedge clk);
        trigger = 1'b0;
        check("done_trig_busy0", int'(busy0), 0);
        check("done_trig_busy1", int'(busy1), 0);
        repeat (3) @(negedge clk);
        check("done_trig_idle", int'(busy0), 0);

        // Effect 3, half volume: note changes at 1600, 3200, 4800.
        volume = 4'd8;
        push_exp(6400, 6400, 1);
        pulse(2'd3);
        tone_window("e3_note0", 0, 38, 120);
        run_to(1600);
        tone_window("e3_note1", 1600, 30, 100);
        run_to(3200);
        tone_window("e3_note2", 3200, 25, 80);
        run_to(4800);
        tone_window("e3_note3", 4800, 19, 60);
        wait_done(0, "e3_done", hi);

        // Retrigger effect 1 with effect 0 at offset 3000.
        volume = 4'd15;
        push_exp(5001, 16000, 1);
        pulse(2'd1);
        run_to(3000);
        trigger    = 1'b1;
        effect_sel = 2'd0;
        step();
        trigger = 1'b0;
        check("retrig_busy", int'(busy0), 1);
        check("retrig_no_done", int'(done0), 0);
        tone_window("retrig_note0", 3001, 11, 60);
        wait_done(0, "retrig_done", hi);
        wait_done(1, "noretrig_done", hi);

        // Reset in the middle of effect 2, then play effect 0 again.
        push_exp(-1, -1, 0);
        pulse(2'd2);
        run_to(1000);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy0), 0);
        check("abort_done", int'(done0), 0);
        check("abort_pwm",  int'(pwm0),  0);
        check("abort_sd",   int'(sd0),   0);
        check("abort_busy_nr", int'(busy1), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", int'(busy0), 0);
        push_exp(2000, 2000, 1);
        pulse(2'd0);
        tone_window("e0b_note0", 0, 11, 60);
        wait_done(0, "e0b_done", hi);

        repeat (3) @(negedge clk);
        check("sb_left0", q0.size(), 0);
        check("sb_left1", q1.size(), 0);
        check("sd_tracks_busy", sd_err, 0);
        check("done_while_busy", both_err, 0);
        check("done_pulses0", done_cnt[0], 5);
        check("done_pulses1", done_cnt[1], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sfx_player.md
SFX_PLAYER -- requirements
Module: sfx_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter DUTY_W, default 4, meaning width of the volume field and the PWM carrier counter.
REQ-003 SHALL have parameter ALLOW_RETRIG, default 1, meaning 1 = trigger while busy restarts playback, 0 = trigger while busy is ignored.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 trigger  input  1  start request, sampled on the rising clk edge.
REQ-007 effect_sel  input  2  effect index, latched together with an accepted trigger.
REQ-008 volume  input  DUTY_W  carrier duty; sampled continuously, not latched.
REQ-009 busy  output  1  high while an effect is playing.
REQ-010 done  output  1  one-cycle pulse when an effect completes.
REQ-011 AUD_PWM  output  1  audio PWM to the amplifier.
REQ-012 AUD_SD  output  1  amplifier enable, equal to busy.

Function
REQ-013 Note half-period SHALL be CLK_HZ/(2*f), integer-truncated at elaboration; the duration tick SHALL be CLK_HZ/1000 cycles (1 ms).
REQ-014 Fixed effect table (frequency Hz / duration ms) SHALL be as follows:
- 0 EAT: 880/50, 1320/50.
- 1 GAME_OVER: 440/200, 330/200, 262/400.
- 2 ALARM: 880/100, 440/100, 880/100, 440/100.
- 3 START: 262/80, 330/80, 392/80, 523/80.
REQ-015 FSM SHALL have states IDLE, PLAY and DONE.
- IDLE -> PLAY on trigger.
- PLAY -> DONE after the last note's final ms tick.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 Accepted trigger in IDLE SHALL assert busy on the next cycle; note 0 and the tone phase (low) SHALL start that same cycle, and the ms counter and note counter SHALL clear.
REQ-017 Tone square wave SHALL toggle every half-period cycles; the half-period counter SHALL reload and the phase SHALL reset low at every note boundary.
REQ-018 AUD_PWM SHALL equal tone_phase AND (pwm_cnt < volume), where pwm_cnt is a free-running DUTY_W-bit counter that wraps at 2^DUTY_W-1 -> 0.
REQ-019 volume = 0 SHALL give AUD_PWM constantly 0 while playback timing continues; volume = 2^DUTY_W-1 SHALL give a duty of (2^DUTY_W-1)/2^DUTY_W.
REQ-020 In DONE, busy SHALL be 0, done SHALL be 1 and AUD_PWM SHALL be 0; in IDLE, AUD_PWM SHALL be 0.
REQ-021 Trigger in DONE SHALL be ignored.
REQ-022 Trigger in PLAY with ALLOW_RETRIG=1 SHALL latch the new effect_sel and restart per REQ-016 without pulsing done; with ALLOW_RETRIG=0 it SHALL be ignored.
REQ-023 Effect duration SHALL be exact: sum of ms durations x CLK_HZ/1000 cycles from the first busy cycle to the last busy cycle inclusive.
REQ-024 Counters SHALL be sized by $clog2 of their maximum count; no counter SHALL overflow for CLK_HZ up to 200_000_000.

Reset
REQ-025 rst_n low SHALL immediately force:
- state IDLE;
- busy=0, done=0, AUD_PWM=0, AUD_SD=0;
- all counters, tone phase and the latched effect cleared.
REQ-026 Reset asserted mid-effect SHALL abort playback with no done pulse; after release the block SHALL wait in IDLE for a new trigger.

Verification (CLK_HZ=1_000_000, DUTY_W=4)
REQ-027 Single-cycle trigger with effect_sel=0 and volume=15 -> busy high for exactly 100000 cycles; AUD_PWM tone half-periods of 568 cycles, then 378 cycles; one done pulse; AUD_SD tracks busy.
REQ-028 Effect 1 with volume=0 -> busy for 800000 cycles, AUD_PWM never high, done pulses once.
REQ-029 Effect 3 with volume=8 -> within a high tone phase AUD_PWM high for 8 of every 16 cycles; note changes at cycles 80000, 160000 and 240000 after busy rises.
REQ-030 ALLOW_RETRIG=1, effect 1 retriggered with effect 0 at cycle 150000 -> no done pulse at the retrigger; busy lasts 100000 more cycles; one done pulse at the end.
REQ-031 ALLOW_RETRIG=0, same stimulus as REQ-030 -> retrigger ignored; effect 1 completes at cycle 800000.
REQ-032 rst_n pulsed low at cycle 50000 of effect 2 -> all outputs 0 asynchronously, no done pulse; a new trigger after release plays normally.
